// File: rtl/spi_master_mss_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_master_mss_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      P0,
      P1,
      HOLD,
      GAP
   } spi_state_e;

   typedef struct packed {
      logic cpol;
      logic cpha;
      logic lsb;
   } spi_mode_t;

   // Slave-select index width; a single slave still needs one select bit.
   function automatic int unsigned ss_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_master_mss_if.sv
// Front-end handshake plus serial pins of the SPI master, grouped as one bundle.
interface spi_master_mss_if
   import spi_master_mss_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_SS = 4,
   parameter int unsigned DVSR_W = 16
);
   localparam int unsigned SS_W = ss_width(NUM_SS);

   logic [DATA_W-1:0] din_i;
   logic [DVSR_W-1:0] dvsr_i;
   logic              start_i;
   logic              cpol_i;
   logic              cpha_i;
   logic              lsb_first_i;
   logic [SS_W-1:0]   ss_sel_i;
   logic              hold_ss_i;
   logic              ss_release_i;
   logic              miso_i;
   logic [DATA_W-1:0] dout_o;
   logic              spi_done_tick_o;
   logic              ready_o;
   logic              sclk_o;
   logic              mosi_o;
   logic [NUM_SS-1:0] ss_n_o;

   modport master (
      input  din_i, dvsr_i, start_i, cpol_i, cpha_i, lsb_first_i,
      input  ss_sel_i, hold_ss_i, ss_release_i, miso_i,
      output dout_o, spi_done_tick_o, ready_o, sclk_o, mosi_o, ss_n_o
   );

   modport slave (
      output din_i, dvsr_i, start_i, cpol_i, cpha_i, lsb_first_i,
      output ss_sel_i, hold_ss_i, ss_release_i, miso_i,
      input  dout_o, spi_done_tick_o, ready_o, sclk_o, mosi_o, ss_n_o
   );

endinterface

// File: rtl/spi_master_mss_clk_div.sv
// Phase timer: down-counter reloaded on phase entry, flags the last cycle of a phase.
module spi_master_mss_clk_div #(
   parameter int unsigned DVSR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DVSR_W-1:0] load_val,
   output logic              last_c
);

   logic [DVSR_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - DVSR_W'(1);
      end
   end

   assign last_c = (cnt == '0);

endmodule

// File: rtl/spi_master_mss.sv
// SPI master: FSM, bit counter, shared tx/rx shift register and chip-select decode.
module spi_master_mss
   import spi_master_mss_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_SS = 4,
   parameter int unsigned DVSR_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   spi_master_mss_if.master bus
);

   localparam int unsigned SS_W  = ss_width(NUM_SS);
   localparam int unsigned BIT_W = $clog2(DATA_W);

   spi_state_e        state;
   spi_mode_t         mode;
   logic [DVSR_W-1:0] dvsr_q;
   logic [SS_W-1:0]   sel_q;
   logic              hold_q;
   logic [DATA_W-1:0] sr;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] dout;
   logic              done;
   logic              ready;
   logic              sclk;
   logic              mosi;
   logic [NUM_SS-1:0] ss_n;

   logic              accept_c;
   logic              busy_c;
   logic              last_c;
   logic              load_c;
   logic [DVSR_W-1:0] load_val_c;

   function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
      return lsb ? d[0] : d[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] d,
                                                  input logic b, input logic lsb);
      return lsb ? {b, d[DATA_W-1:1]} : {d[DATA_W-2:0], b};
   endfunction

   // Out-of-range indices leave every select deasserted.
   function automatic logic [NUM_SS-1:0] cs_decode(input logic [SS_W-1:0] s);
      logic [NUM_SS-1:0] v;
      v = '1;
      for (int unsigned i = 0; i < NUM_SS; i++) begin
         if (SS_W'(i) == s) v[i] = 1'b0;
      end
      return v;
   endfunction

   assign accept_c   = bus.start_i & ((state == IDLE) | (state == HOLD));
   assign busy_c     = (state == SETUP) | (state == P0) | (state == P1) | (state == GAP);
   assign load_c     = accept_c | (busy_c & last_c);
   assign load_val_c = accept_c ? bus.dvsr_i : dvsr_q;

   spi_master_mss_clk_div #(.DVSR_W(DVSR_W)) u_clk_div (
      .clk      (clk_i),
      .rst      (rst_i),
      .load     (load_c),
      .load_val (load_val_c),
      .last_c   (last_c)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         mode    <= '0;
         dvsr_q  <= '0;
         sel_q   <= '0;
         hold_q  <= 1'b0;
         sr      <= '0;
         bit_cnt <= '0;
         dout    <= '0;
         done    <= 1'b0;
         ready   <= 1'b1;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         ss_n    <= '1;
      end else begin
         done <= 1'b0;
         // Transfer parameters are captured once and then ignored until the next accept.
         if (accept_c) begin
            mode    <= '{cpol: bus.cpol_i, cpha: bus.cpha_i, lsb: bus.lsb_first_i};
            dvsr_q  <= bus.dvsr_i;
            sel_q   <= bus.ss_sel_i;
            hold_q  <= bus.hold_ss_i;
            sr      <= bus.din_i;
            mosi    <= first_bit(bus.din_i, bus.lsb_first_i);
            bit_cnt <= '0;
            ready   <= 1'b0;
         end
         case (state)
            IDLE: begin
               sclk <= bus.cpol_i;
               if (accept_c) begin
                  state <= SETUP;
                  ss_n  <= cs_decode(bus.ss_sel_i);
               end
            end
            SETUP: begin
               sclk <= mode.cpol;
               if (last_c) begin
                  state <= P0;
                  sclk  <= mode.cpha ^ mode.cpol;
               end
            end
            P0: begin
               if (last_c) begin
                  state <= P1;
                  sclk  <= ~mode.cpha ^ mode.cpol;
                  sr    <= shift_in(sr, bus.miso_i, mode.lsb);
               end
            end
            P1: begin
               if (last_c) begin
                  if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                     done  <= 1'b1;
                     dout  <= sr;
                     ready <= 1'b1;
                     sclk  <= mode.cpol;
                     if (hold_q) begin
                        state <= HOLD;
                     end else begin
                        state <= IDLE;
                        ss_n  <= '1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     state   <= P0;
                     sclk    <= mode.cpha ^ mode.cpol;
                     mosi    <= first_bit(sr, mode.lsb);
                  end
               end
            end
            HOLD: begin
               sclk <= mode.cpol;
               if (accept_c) begin
                  if (bus.ss_sel_i == sel_q) begin
                     state <= P0;
                     sclk  <= bus.cpha_i ^ bus.cpol_i;
                  end else begin
                     state <= GAP;
                     ss_n  <= '1;
                  end
               end else if (bus.ss_release_i) begin
                  state <= IDLE;
                  ss_n  <= '1;
               end
            end
            GAP: begin
               sclk <= mode.cpol;
               if (last_c) begin
                  state <= SETUP;
                  ss_n  <= cs_decode(sel_q);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.dout_o          = dout;
   assign bus.spi_done_tick_o = done;
   assign bus.ready_o         = ready;
   assign bus.sclk_o          = sclk;
   assign bus.mosi_o          = mosi;
   assign bus.ss_n_o          = ss_n;

endmodule

// File: tb/tb_spi_master_mss.sv
// Randomised self-checking bench for spi_master_mss against a frame-level reference model.
module tb_spi_master_mss;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic loopback = 1'b1;
   logic miso_const = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int         r_lat, r_edges, r_cs_first, r_gap_max;
   logic       r_timeout, r_cs_stable, r_high_ok, r_first_mosi;
   logic [7:0] r_dout, r_mosi;
   logic [3:0] r_pre_ss;

   always #5 clk = ~clk;

   spi_master_mss_if #(.DATA_W(8), .NUM_SS(4), .DVSR_W(16)) bus ();
   spi_master_mss_if #(.DATA_W(8), .NUM_SS(3), .DVSR_W(16)) bus_b ();

   spi_master_mss #(.DATA_W(8), .NUM_SS(4), .DVSR_W(16)) dut (
      .clk_i (clk), .rst_i (rst), .bus (bus.master));
   spi_master_mss #(.DATA_W(8), .NUM_SS(3), .DVSR_W(16)) dut_b (
      .clk_i (clk), .rst_i (rst), .bus (bus_b.master));

   assign bus.miso_i   = loopback ? bus.mosi_o : miso_const;
   assign bus_b.miso_i = bus_b.mosi_o;

   // Expected one-hot-low select pattern for slave index sel.
   function automatic logic [3:0] cs_of(input int sel);
      logic [3:0] v;
      v = 4'hF;
      if (sel < 4) v[sel] = 1'b0;
      return v;
   endfunction

   // Cycles from the start cycle to the done cycle, given how many dvsr+1 phases run.
   function automatic int lat_of(input int dvsr, input int phases);
      return 1 + phases * (dvsr + 1);
   endfunction

   // Runs one frame on bus and records what an SPI slave would observe.
   task automatic do_frame(input logic [7:0] din, input int dvsr, input logic cpol,
                           input logic cpha, input logic lsb, input int sel,
                           input logic hold, input logic rel);
      logic prev;
      int   bitn;
      int   last_edge;
      bus.cpol_i = cpol; bus.cpha_i = cpha; bus.start_i = 1'b0; bus.ss_release_i = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      r_pre_ss = bus.ss_n_o;
      bus.din_i = din; bus.dvsr_i = 16'(dvsr); bus.lsb_first_i = lsb;
      bus.ss_sel_i = 2'(sel); bus.hold_ss_i = hold; bus.ss_release_i = rel; bus.start_i = 1'b1;
      prev = bus.sclk_o; bitn = 0; last_edge = 0;
      r_edges = 0; r_gap_max = 0; r_mosi = '0; r_dout = '0; r_lat = 0; r_timeout = 1'b1;
      r_cs_first = 0; r_cs_stable = 1'b1; r_high_ok = 1'b1; r_first_mosi = 1'b0;
      for (int k = 1; k <= 4000; k++) begin
         @(posedge clk); #1;
         if (k == 1) r_first_mosi = bus.mosi_o;
         if (bus.sclk_o !== prev) begin
            r_edges++;
            if (last_edge != 0 && (k - last_edge) > r_gap_max) r_gap_max = k - last_edge;
            last_edge = k;
            if (((bus.sclk_o != cpol) == !cpha) && bitn < 8) begin
               if (lsb) r_mosi[bitn] = bus.mosi_o;
               else     r_mosi[7-bitn] = bus.mosi_o;
               bitn++;
            end
            prev = bus.sclk_o;
         end
         if (bus.spi_done_tick_o === 1'b1) begin
            r_lat = k; r_dout = bus.dout_o; r_timeout = 1'b0;
            bus.start_i = 1'b0; bus.ss_release_i = 1'b0;
            break;
         end
         if (r_cs_first == 0) begin
            if (bus.ss_n_o === cs_of(sel)) r_cs_first = k;
            else if (bus.ss_n_o !== 4'hF) r_high_ok = 1'b0;
         end else if (bus.ss_n_o !== cs_of(sel)) begin
            r_cs_stable = 1'b0;
         end
         // Busy: everything on the request side must be ignored.
         bus.din_i = 8'($urandom); bus.dvsr_i = 16'($urandom_range(0, 7));
         bus.cpol_i = 1'($urandom); bus.cpha_i = 1'($urandom); bus.lsb_first_i = 1'($urandom);
         bus.ss_sel_i = 2'($urandom); bus.hold_ss_i = 1'($urandom);
         bus.ss_release_i = 1'($urandom); bus.start_i = 1'($urandom);
      end
      bus.start_i = 1'b0; bus.ss_release_i = 1'b0;
   endtask

   task automatic test_reset();
      bus.din_i = '0; bus.dvsr_i = '0; bus.start_i = 0; bus.cpol_i = 0; bus.cpha_i = 0;
      bus.lsb_first_i = 0; bus.ss_sel_i = '0; bus.hold_ss_i = 0; bus.ss_release_i = 0;
      bus_b.din_i = '0; bus_b.dvsr_i = '0; bus_b.start_i = 0; bus_b.cpol_i = 0; bus_b.cpha_i = 0;
      bus_b.lsb_first_i = 0; bus_b.ss_sel_i = '0; bus_b.hold_ss_i = 0; bus_b.ss_release_i = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.ss_n_o !== 4'hF) begin errors++; $display("FAIL reset_ss_n: got %h expected f", bus.ss_n_o); end
      checks++; if (bus.sclk_o !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", bus.sclk_o); end
      checks++; if (bus.mosi_o !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", bus.mosi_o); end
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready_o); end
      checks++; if (bus.spi_done_tick_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.spi_done_tick_o); end
      checks++; if (bus.dout_o !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", bus.dout_o); end
      checks++; if (bus_b.ss_n_o !== 3'b111) begin errors++; $display("FAIL reset_ss_n_b: got %b expected 111", bus_b.ss_n_o); end
      rst = 1'b0;
   endtask

   task automatic test_modes();
      loopback = 1'b1;
      for (int m = 0; m < 4; m++) begin
         do_frame(8'hA5, 4, m[1], m[0], 1'b0, m, 1'b0, 1'b0);
         checks++; if (r_timeout !== 1'b0) begin errors++; $display("FAIL modes_timeout m=%0d: no done tick", m); end
         checks++; if (r_lat != lat_of(4, 17)) begin errors++; $display("FAIL modes_latency m=%0d: got %0d expected %0d", m, r_lat, lat_of(4, 17)); end
         checks++; if (r_dout !== 8'hA5) begin errors++; $display("FAIL modes_dout m=%0d: got %h expected a5", m, r_dout); end
         checks++; if (r_mosi !== 8'hA5) begin errors++; $display("FAIL modes_mosi m=%0d: got %h expected a5", m, r_mosi); end
         checks++; if (r_edges != 16) begin errors++; $display("FAIL modes_edges m=%0d: got %0d expected 16", m, r_edges); end
         checks++; if (r_cs_first != 1 || r_cs_stable !== 1'b1) begin errors++; $display("FAIL modes_cs m=%0d: first %0d stable %b expected 1 1", m, r_cs_first, r_cs_stable); end
         @(posedge clk); #1;
         checks++; if (bus.spi_done_tick_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.ss_n_o !== 4'hF) begin
            errors++; $display("FAIL modes_after m=%0d: done %b ready %b ss_n %h expected 0 1 f", m, bus.spi_done_tick_o, bus.ready_o, bus.ss_n_o); end
      end
   endtask

   task automatic test_random();
      logic [7:0] din, exp;
      int dvsr, sel;
      logic cpol, cpha, lsb;
      for (int i = 0; i < 10; i++) begin
         din = 8'($urandom); dvsr = $urandom_range(0, 5); sel = $urandom_range(0, 3);
         cpol = 1'($urandom); cpha = 1'($urandom); lsb = 1'($urandom);
         loopback = 1'($urandom); miso_const = 1'($urandom);
         exp = loopback ? din : {8{miso_const}};
         do_frame(din, dvsr, cpol, cpha, lsb, sel, 1'b0, 1'b0);
         checks++; if (r_lat != lat_of(dvsr, 17)) begin errors++; $display("FAIL rand_latency i=%0d: got %0d expected %0d", i, r_lat, lat_of(dvsr, 17)); end
         checks++; if (r_dout !== exp) begin errors++; $display("FAIL rand_dout i=%0d: got %h expected %h", i, r_dout, exp); end
         checks++; if (r_mosi !== din) begin errors++; $display("FAIL rand_mosi i=%0d: got %h expected %h", i, r_mosi, din); end
         checks++; if (r_cs_first != 1 || r_cs_stable !== 1'b1) begin errors++; $display("FAIL rand_cs i=%0d: first %0d stable %b expected 1 1", i, r_cs_first, r_cs_stable); end
      end
      loopback = 1'b1;
   endtask

   task automatic test_lsb_first();
      loopback = 1'b0; miso_const = 1'b1;
      do_frame(8'h01, 2, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      checks++; if (r_first_mosi !== 1'b1) begin errors++; $display("FAIL lsb_first_bit: got %b expected 1", r_first_mosi); end
      checks++; if (r_mosi !== 8'h01) begin errors++; $display("FAIL lsb_mosi: got %h expected 01", r_mosi); end
      checks++; if (r_dout !== 8'hFF) begin errors++; $display("FAIL lsb_dout: got %h expected ff", r_dout); end
      checks++; if (r_edges != 16) begin errors++; $display("FAIL lsb_edges: got %0d expected 16", r_edges); end
      loopback = 1'b1;
   endtask

   task automatic test_burst();
      logic [7:0] din;
      loopback = 1'b1;
      for (int f = 0; f < 3; f++) begin
         din = 8'($urandom);
         do_frame(din, 3, 1'b0, 1'b0, 1'b0, 2, 1'b1, (f == 2));
         checks++; if (r_lat != lat_of(3, (f == 0) ? 17 : 16)) begin errors++; $display("FAIL burst_latency f=%0d: got %0d expected %0d", f, r_lat, lat_of(3, (f == 0) ? 17 : 16)); end
         checks++; if (r_dout !== din) begin errors++; $display("FAIL burst_dout f=%0d: got %h expected %h", f, r_dout, din); end
         checks++; if (r_cs_first != 1 || r_cs_stable !== 1'b1) begin errors++; $display("FAIL burst_cs f=%0d: first %0d stable %b expected 1 1", f, r_cs_first, r_cs_stable); end
         if (f > 0) begin
            checks++; if (r_pre_ss !== 4'b1011) begin errors++; $display("FAIL burst_hold_ss f=%0d: got %b expected 1011", f, r_pre_ss); end
         end
      end
      @(posedge clk); #1;
      checks++; if (bus.ss_n_o !== 4'b1011 || bus.ready_o !== 1'b1) begin errors++; $display("FAIL burst_held: ss_n %b ready %b expected 1011 1", bus.ss_n_o, bus.ready_o); end
      bus.ss_release_i = 1'b1;
      @(posedge clk); #1;
      bus.ss_release_i = 1'b0;
      checks++; if (bus.ss_n_o !== 4'hF) begin errors++; $display("FAIL burst_release: got %b expected 1111", bus.ss_n_o); end
   endtask

   task automatic test_gap();
      logic [7:0] din;
      loopback = 1'b1;
      do_frame(8'($urandom), 3, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
      din = 8'($urandom);
      do_frame(din, 3, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0);
      checks++; if (r_pre_ss !== 4'b1101) begin errors++; $display("FAIL gap_hold_ss: got %b expected 1101", r_pre_ss); end
      checks++; if (r_cs_first != 3 + 2) begin errors++; $display("FAIL gap_cs_delay: got %0d expected 5", r_cs_first); end
      checks++; if (r_high_ok !== 1'b1 || r_cs_stable !== 1'b1) begin errors++; $display("FAIL gap_cs_shape: high %b stable %b expected 1 1", r_high_ok, r_cs_stable); end
      checks++; if (r_lat != lat_of(3, 18)) begin errors++; $display("FAIL gap_latency: got %0d expected %0d", r_lat, lat_of(3, 18)); end
      checks++; if (r_dout !== din) begin errors++; $display("FAIL gap_dout: got %h expected %h", r_dout, din); end
   endtask

   task automatic test_fast_oob();
      logic [7:0] din;
      logic ss_ok;
      int lat;
      din = 8'($urandom);
      do_frame(din, 0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
      checks++; if (r_lat != lat_of(0, 17)) begin errors++; $display("FAIL fast_latency: got %0d expected %0d", r_lat, lat_of(0, 17)); end
      checks++; if (r_edges != 16 || r_gap_max != 1) begin errors++; $display("FAIL fast_sclk: edges %0d gap %0d expected 16 1", r_edges, r_gap_max); end
      checks++; if (r_dout !== din) begin errors++; $display("FAIL fast_dout: got %h expected %h", r_dout, din); end
      din = 8'($urandom);
      bus_b.cpol_i = 0; bus_b.cpha_i = 0; bus_b.lsb_first_i = 0; bus_b.dvsr_i = '0;
      bus_b.ss_sel_i = 2'd3; bus_b.hold_ss_i = 0; bus_b.din_i = din;
      repeat (2) begin @(posedge clk); #1; end
      bus_b.start_i = 1'b1;
      ss_ok = 1'b1; lat = 0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         bus_b.start_i = 1'b0;
         if (bus_b.ss_n_o !== 3'b111) ss_ok = 1'b0;
         if (bus_b.spi_done_tick_o === 1'b1) begin lat = k; break; end
      end
      checks++; if (lat != lat_of(0, 17)) begin errors++; $display("FAIL oob_latency: got %0d expected %0d", lat, lat_of(0, 17)); end
      checks++; if (ss_ok !== 1'b1) begin errors++; $display("FAIL oob_ss_n: select asserted for out-of-range index"); end
      checks++; if (bus_b.dout_o !== din) begin errors++; $display("FAIL oob_dout: got %h expected %h", bus_b.dout_o, din); end
   endtask

   task automatic test_reset_mid();
      logic prev, seen_done;
      int rises;
      loopback = 1'b1;
      bus.cpol_i = 0; bus.cpha_i = 0; bus.lsb_first_i = 0; bus.dvsr_i = 16'd4;
      bus.ss_sel_i = 2'd0; bus.hold_ss_i = 0; bus.din_i = 8'($urandom);
      repeat (2) begin @(posedge clk); #1; end
      bus.start_i = 1'b1;
      prev = bus.sclk_o; rises = 0; seen_done = 1'b0;
      for (int k = 1; k <= 500; k++) begin
         @(posedge clk); #1;
         bus.start_i = 1'b0;
         if (bus.spi_done_tick_o === 1'b1) seen_done = 1'b1;
         if (bus.sclk_o === 1'b1 && prev === 1'b0) rises++;
         prev = bus.sclk_o;
         if (rises == 4) break;
      end
      checks++; if (rises != 4 || bus.ss_n_o !== 4'b1110) begin errors++; $display("FAIL rstmid_reach: rises %0d ss_n %b expected 4 1110", rises, bus.ss_n_o); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.ss_n_o !== 4'hF) begin errors++; $display("FAIL rstmid_ss_n: got %h expected f", bus.ss_n_o); end
      checks++; if (bus.sclk_o !== 1'b0) begin errors++; $display("FAIL rstmid_sclk: got %b expected 0", bus.sclk_o); end
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", bus.ready_o); end
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (bus.spi_done_tick_o === 1'b1) seen_done = 1'b1;
      end
      checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: done pulse observed after abort"); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_modes();
      test_random();
      test_lsb_first();
      test_burst();
      test_gap();
      test_fast_oob();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
